// File: rtl/raif_pkg.sv
// Shared definitions for the RAIF read/write scheduling slice.
//   - default address/data widths, beat-count width
//   - scheduler state encoding and direction constants
package raif_pkg;

  localparam int unsigned RAIF_APP_ADDR_WIDTH = 28;
  localparam int unsigned RAIF_APP_DATA_WIDTH = 128;
  localparam int unsigned RAIF_NUM_W          = 10;

  // Width of the consecutive same-direction counter (saturates at 15).
  localparam int unsigned RAIF_SAME_W = 4;

  localparam logic DIR_WR = 1'b0;
  localparam logic DIR_RD = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD,
    GAP,
    TURN
  } raif_state_e;

endpackage

// File: rtl/raif_rw_pick.sv
// Combinational read/write pick rule.
// Ports:
//   wr_req, rd_req : pending requests
//   last_dir       : direction of the previous transaction (0 = write)
//   same_cnt       : consecutive transactions in last_dir
//   dir            : chosen direction (only meaningful with a request)
//   turn           : chosen direction differs from last_dir
module raif_rw_pick
  import raif_pkg::*;
#(
  parameter int unsigned MAX_SAME = 4
) (
  input  logic                   wr_req,
  input  logic                   rd_req,
  input  logic                   last_dir,
  input  logic [RAIF_SAME_W-1:0] same_cnt,
  output logic                   dir,
  output logic                   turn
);

  always_comb begin
    dir = last_dir;
    if (wr_req && !rd_req) begin
      dir = DIR_WR;
    end else if (rd_req && !wr_req) begin
      dir = DIR_RD;
    end else if (wr_req && rd_req) begin
      // Stay with the current direction until it has had MAX_SAME turns.
      dir = (32'(same_cnt) < MAX_SAME) ? last_dir : ~last_dir;
    end
    turn = (wr_req || rd_req) && (dir != last_dir);
  end

endmodule

// File: rtl/raif_rw_sched.sv
// Read/write direction scheduler in front of a single-port command engine.
// Grants one direction at a time, bounds same-direction bursts to MAX_SAME
// while the other side waits, and inserts TURN_CYC idle cycles on a
// direction change. One idle GAP cycle follows every finish.
// Ports:
//   wr_*  : write requester (req level, addr, num, data in; grant/finish out)
//   rd_*  : read requester (req level, addr, num in; data/grant/finish out)
//   cmd_* : downstream command port (req/we/addr/num/wdata out;
//           rdata/grant/finish in)
// Optional: define RAIF_RW_SCHED_STAT_EN to add stat_wr_cnt, stat_rd_cnt
// and stat_turn_cnt (32-bit, wrapping) outputs.
module raif_rw_sched
  import raif_pkg::*;
#(
  parameter int unsigned APP_DATA_WIDTH = RAIF_APP_DATA_WIDTH,
  parameter int unsigned APP_ADDR_WIDTH = RAIF_APP_ADDR_WIDTH,
  parameter int unsigned MAX_SAME       = 4,
  parameter int unsigned TURN_CYC       = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      wr_req,
  input  logic [APP_ADDR_WIDTH-1:0] wr_addr,
  input  logic [RAIF_NUM_W-1:0]     wr_num,
  input  logic [APP_DATA_WIDTH-1:0] wr_data,
  output logic                      wr_grant,
  output logic                      wr_finish,
  input  logic                      rd_req,
  input  logic [APP_ADDR_WIDTH-1:0] rd_addr,
  input  logic [RAIF_NUM_W-1:0]     rd_num,
  output logic [APP_DATA_WIDTH-1:0] rd_data,
  output logic                      rd_grant,
  output logic                      rd_finish,
  output logic                      cmd_req,
  output logic                      cmd_we,
  output logic [APP_ADDR_WIDTH-1:0] cmd_addr,
  output logic [RAIF_NUM_W-1:0]     cmd_num,
  output logic [APP_DATA_WIDTH-1:0] cmd_wdata,
  input  logic [APP_DATA_WIDTH-1:0] cmd_rdata,
  input  logic                      cmd_grant,
  input  logic                      cmd_finish
`ifdef RAIF_RW_SCHED_STAT_EN
  ,
  output logic [31:0]               stat_wr_cnt,
  output logic [31:0]               stat_rd_cnt,
  output logic [31:0]               stat_turn_cnt
`endif
);

  raif_state_e            state_q, state_d;
  logic                   dir_q, dir_d;
  logic                   last_dir_q, last_dir_d;
  logic [RAIF_SAME_W-1:0] same_cnt_q, same_cnt_d;
  logic [3:0]             turn_cnt_q, turn_cnt_d;
  logic                   cmd_req_q, cmd_req_d;
  logic                   pick_dir, pick_turn;

  raif_rw_pick #(
    .MAX_SAME (MAX_SAME)
  ) u_pick (
    .wr_req   (wr_req),
    .rd_req   (rd_req),
    .last_dir (last_dir_q),
    .same_cnt (same_cnt_q),
    .dir      (pick_dir),
    .turn     (pick_turn)
  );

  always_comb begin
    state_d    = state_q;
    dir_d      = dir_q;
    last_dir_d = last_dir_q;
    same_cnt_d = same_cnt_q;
    turn_cnt_d = turn_cnt_q;
    cmd_req_d  = cmd_req_q;
    unique case (state_q)
      IDLE: begin
        if (wr_req || rd_req) begin
          // Direction and burst accounting are committed at pick time, so a
          // request change during TURN cannot alter the chosen side.
          dir_d      = pick_dir;
          last_dir_d = pick_dir;
          if (pick_turn) begin
            same_cnt_d = RAIF_SAME_W'(1);
          end else if (same_cnt_q != '1) begin
            same_cnt_d = same_cnt_q + RAIF_SAME_W'(1);
          end
          if (pick_turn && (TURN_CYC > 0)) begin
            state_d    = TURN;
            turn_cnt_d = 4'(TURN_CYC - 1);
          end else begin
            state_d   = (pick_dir == DIR_RD) ? RD : WR;
            cmd_req_d = 1'b1;
          end
        end
      end
      TURN: begin
        if (turn_cnt_q == '0) begin
          state_d   = (dir_q == DIR_RD) ? RD : WR;
          cmd_req_d = 1'b1;
        end else begin
          turn_cnt_d = turn_cnt_q - 4'd1;
        end
      end
      WR, RD: begin
        if (cmd_finish) begin
          state_d   = GAP;
          cmd_req_d = 1'b0;
        end
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      dir_q      <= DIR_WR;
      last_dir_q <= DIR_WR;
      same_cnt_q <= '0;
      turn_cnt_q <= '0;
      cmd_req_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      dir_q      <= dir_d;
      last_dir_q <= last_dir_d;
      same_cnt_q <= same_cnt_d;
      turn_cnt_q <= turn_cnt_d;
      cmd_req_q  <= cmd_req_d;
    end
  end

  // Command fields and strobes follow the active side with zero latency.
  always_comb begin
    cmd_we    = 1'b0;
    cmd_addr  = '0;
    cmd_num   = '0;
    wr_grant  = 1'b0;
    wr_finish = 1'b0;
    rd_grant  = 1'b0;
    rd_finish = 1'b0;
    unique case (state_q)
      WR: begin
        cmd_we    = 1'b1;
        cmd_addr  = wr_addr;
        cmd_num   = wr_num;
        wr_grant  = cmd_grant;
        wr_finish = cmd_finish;
      end
      RD: begin
        cmd_addr  = rd_addr;
        cmd_num   = rd_num;
        rd_grant  = cmd_grant;
        rd_finish = cmd_finish;
      end
      default: ;
    endcase
  end

  assign cmd_req   = cmd_req_q;
  assign cmd_wdata = wr_data;
  assign rd_data   = cmd_rdata;

`ifdef RAIF_RW_SCHED_STAT_EN
  logic [31:0] stat_wr_cnt_q, stat_wr_cnt_d;
  logic [31:0] stat_rd_cnt_q, stat_rd_cnt_d;
  logic [31:0] stat_turn_cnt_q, stat_turn_cnt_d;

  always_comb begin
    stat_wr_cnt_d   = stat_wr_cnt_q + 32'(wr_finish);
    stat_rd_cnt_d   = stat_rd_cnt_q + 32'(rd_finish);
    stat_turn_cnt_d = stat_turn_cnt_q
                    + 32'((state_q == IDLE) && (state_d == TURN));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_wr_cnt_q   <= '0;
      stat_rd_cnt_q   <= '0;
      stat_turn_cnt_q <= '0;
    end else begin
      stat_wr_cnt_q   <= stat_wr_cnt_d;
      stat_rd_cnt_q   <= stat_rd_cnt_d;
      stat_turn_cnt_q <= stat_turn_cnt_d;
    end
  end

  assign stat_wr_cnt   = stat_wr_cnt_q;
  assign stat_rd_cnt   = stat_rd_cnt_q;
  assign stat_turn_cnt = stat_turn_cnt_q;
`endif

endmodule
